// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Serialises fetch and data requests onto one SRAM-like memory port,
//            data side first, with registered completion pulses and stalls.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inst_req,
   input  logic [AW-1:0] inst_addr,
   input  logic          inst_cancel,
   output logic [DW-1:0] inst_rdata,
   output logic          inst_data_ok,
   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [3:0]    data_wstrb,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic [DW-1:0] data_rdata,
   output logic          data_data_ok,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [1:0]    mem_size,
   output logic [3:0]    mem_wstrb,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_addr_ok,
   input  logic          mem_data_ok,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall_inst,
   output logic          stall_data
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_ADDR = 3'd1,
      I_DATA = 3'd2,
      D_ADDR = 3'd3,
      D_DATA = 3'd4
   } stateT;

   stateT         r_state;
   stateT         w_nextState;
   logic          w_instDone;
   logic          w_dataDone;
   logic          w_instKeep;
   logic          w_instSide;
   logic          r_drop;
   logic          r_instOk;
   logic          r_dataOk;
   logic [DW-1:0] r_instRdata;
   logic [DW-1:0] r_dataRdata;
   logic          r_memWr;
   logic [1:0]    r_memSize;
   logic [3:0]    r_memWstrb;
   logic [AW-1:0] r_memAddr;
   logic [DW-1:0] r_memWdata;

   always_comb begin
      w_nextState = r_state;
      w_instDone  = 1'b0;
      w_dataDone  = 1'b0;
      case (r_state)
         IDLE: begin
            // A side whose completion pulse is out this cycle must not be re-granted.
            if (data_req && !r_dataOk)
               w_nextState = D_ADDR;
            else if (inst_req && !r_instOk && !inst_cancel)
               w_nextState = I_ADDR;
         end
         I_ADDR: begin
            if (mem_addr_ok) begin
               if (mem_data_ok) begin
                  w_nextState = IDLE;
                  w_instDone  = 1'b1;
               end else begin
                  w_nextState = I_DATA;
               end
            end
         end
         I_DATA: begin
            if (mem_data_ok) begin
               w_nextState = IDLE;
               w_instDone  = 1'b1;
            end
         end
         D_ADDR: begin
            if (mem_addr_ok) begin
               if (mem_data_ok) begin
                  w_nextState = IDLE;
                  w_dataDone  = 1'b1;
               end else begin
                  w_nextState = D_DATA;
               end
            end
         end
         D_DATA: begin
            if (mem_data_ok) begin
               w_nextState = IDLE;
               w_dataDone  = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign w_instSide = (r_state == I_ADDR) || (r_state == I_DATA);
   // A cancel arriving in the completion cycle itself also discards the fetch.
   assign w_instKeep = w_instDone && !r_drop && !inst_cancel;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_drop      <= 1'b0;
         r_instOk    <= 1'b0;
         r_dataOk    <= 1'b0;
         r_instRdata <= '0;
         r_dataRdata <= '0;
         r_memWr     <= 1'b0;
         r_memSize   <= 2'd0;
         r_memWstrb  <= 4'd0;
         r_memAddr   <= '0;
         r_memWdata  <= '0;
      end else begin
         r_state  <= w_nextState;
         r_instOk <= w_instKeep;
         r_dataOk <= w_dataDone;
         if (w_instKeep)
            r_instRdata <= mem_rdata;
         if (w_dataDone && !r_memWr)
            r_dataRdata <= mem_rdata;
         if (w_nextState == IDLE)
            r_drop <= 1'b0;
         else if (w_instSide && inst_cancel)
            r_drop <= 1'b1;
         if (r_state == IDLE && w_nextState == D_ADDR) begin
            r_memWr    <= data_wr;
            r_memSize  <= data_size;
            r_memWstrb <= data_wstrb;
            r_memAddr  <= data_addr;
            r_memWdata <= data_wdata;
         end else if (r_state == IDLE && w_nextState == I_ADDR) begin
            r_memWr    <= 1'b0;
            r_memSize  <= 2'd2;
            r_memWstrb <= 4'd0;
            r_memAddr  <= inst_addr;
            r_memWdata <= '0;
         end
      end
   end

   assign mem_req      = (r_state == I_ADDR) || (r_state == D_ADDR);
   assign mem_wr       = r_memWr;
   assign mem_size     = r_memSize;
   assign mem_wstrb    = r_memWstrb;
   assign mem_addr     = r_memAddr;
   assign mem_wdata    = r_memWdata;
   assign inst_rdata   = r_instRdata;
   assign data_rdata   = r_dataRdata;
   assign inst_data_ok = r_instOk;
   assign data_data_ok = r_dataOk;
   assign stall_inst   = inst_req & ~r_instOk;
   assign stall_data   = data_req & ~r_dataOk;

endmodule
`default_nettype wire
